transmitter: RTL and testbench



---
 rtl/transmitter_pkg.sv | 28 ++
 rtl/transmitter_byte_fifo.sv | 79 +++++++
 rtl/transmitter.sv | 207 ++++++++++++++++++++
 tb/tb_transmitter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// ---------------------------------------------------------------------------
// defines
//   Shared types and constants for the Ethernet transmit frame builder.
//   - address        : destination + source MAC, six bytes each, byte 5 is
//                      the first byte on the wire.
//   - state_t        : frame builder FSM states.
//   - MAC_ADDR_BYTES : bytes per MAC address.
//   - MIN_PAYLOAD    : minimum Ethernet payload, used by optional padding.
// ---------------------------------------------------------------------------
package defines;

    localparam int MAC_ADDR_BYTES = 6;
    localparam int MIN_PAYLOAD    = 46;

    typedef struct packed {
        logic [5:0][7:0] dst;
        logic [5:0][7:0] src;
    } address;

    typedef enum logic [2:0] {
        IDLE,
        DST,
        SRC,
        LEN,
        PAYLOAD
    } state_t;

endpackage

// File: rtl/transmitter_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//   Synchronous DEPTH x 8 FIFO with a registered full flag and a
//   combinational (show-ahead) head byte.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push, din  : write request and data; ignored while full
//     pop        : read request; ignored while empty
//     dout       : current head byte (valid while !empty)
//     full       : registered, high once DEPTH bytes are stored
//     empty      : no bytes stored
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags do, so
    // the array maps onto plain RAM and stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/transmitter.sv
// ---------------------------------------------------------------------------
// transmitter
//   Ethernet frame builder feeding a MAC AXI4-Stream TX port. Latches a
//   header (dst/src MAC + 16-bit length), buffers payload in a byte FIFO and
//   streams dst, src, length and payload as one byte frame with tlast.
//
//   Build option:
//     TRANSMITTER_PAD_EN - when defined, payloads shorter than 46 bytes are
//                          followed by zero bytes up to 46 payload bytes.
//
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     header_addr        : dst/src MAC addresses
//     number_of_bytes    : payload length, [1] is the MSB
//     rx_header_valid    : header load strobe, honoured only in IDLE
//     tx_data, tx_valid  : payload byte push into the FIFO
//     tx_axis_tready     : MAC ready
//     tx_axis_tdata/tvalid/tlast : AXI4-Stream byte output
//     btx_full           : payload FIFO full
// ---------------------------------------------------------------------------
module transmitter
    import defines::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  address          header_addr,
    input  logic [1:0][7:0] number_of_bytes,
    input  logic            rx_header_valid,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    input  logic            tx_axis_tready,
    output logic [7:0]      tx_axis_tdata,
    output logic            tx_axis_tvalid,
    output logic            tx_axis_tlast,
    output logic            btx_full
);

    localparam logic [15:0] LAST_ADDR_IDX = 16'(MAC_ADDR_BYTES - 1);

    state_t          state_q;
    state_t          state_d;
    address          hdr_q;
    logic [1:0][7:0] len_q;
    logic [15:0]     remain_q;
    logic [15:0]     remain_d;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_d;
    logic            hdr_load;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic [2:0]      addr_idx;

`ifdef TRANSMITTER_PAD_EN
    logic            from_fifo;
    logic [16:0]     sent_after;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (btx_full),
        .empty (fifo_empty)
    );

    // Address bytes go out MSB first: count 0 selects byte 5.
    assign addr_idx = 3'd5 - cnt_q[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            len_q    <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            if (hdr_load) begin
                hdr_q <= header_addr;
                len_q <= number_of_bytes;
            end
        end
    end

    // Outputs depend only on registered state and the FIFO head, so tvalid
    // never depends on tready and everything holds while the MAC stalls.
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        remain_d       = remain_q;
        cnt_d          = cnt_q;
        hdr_load       = 1'b0;
        fifo_pop       = 1'b0;
        tx_axis_tdata  = 8'h00;
        tx_axis_tvalid = 1'b0;
        tx_axis_tlast  = 1'b0;
`ifdef TRANSMITTER_PAD_EN
        from_fifo      = 1'b0;
        sent_after     = '0;
`endif

        unique case (state_q)
            IDLE: begin
                if (rx_header_valid) begin
                    hdr_load = 1'b1;
                    remain_d = number_of_bytes;
                    cnt_d    = '0;
                    state_d  = DST;
                end
            end

            DST: begin
                tx_axis_tvalid = 1'b1;
                tx_axis_tdata  = hdr_q.dst[addr_idx];
                if (tx_axis_tready) begin
                    if (cnt_q == LAST_ADDR_IDX) begin
                        cnt_d   = '0;
                        state_d = SRC;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            SRC: begin
                tx_axis_tvalid = 1'b1;
                tx_axis_tdata  = hdr_q.src[addr_idx];
                if (tx_axis_tready) begin
                    if (cnt_q == LAST_ADDR_IDX) begin
                        cnt_d   = '0;
                        state_d = LEN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            LEN: begin
                tx_axis_tvalid = 1'b1;
                tx_axis_tdata  = cnt_q[0] ? len_q[0] : len_q[1];
`ifndef TRANSMITTER_PAD_EN
                // An empty payload ends the frame on the low length byte.
                tx_axis_tlast = cnt_q[0] && (len_q == '0);
`endif
                if (tx_axis_tready) begin
                    if (cnt_q[0]) begin
                        cnt_d   = '0;
                        state_d = tx_axis_tlast ? IDLE : PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            PAYLOAD: begin
`ifdef TRANSMITTER_PAD_EN
                // Once the FIFO share is exhausted, zeros are synthesised
                // here rather than popped; cnt counts all payload bytes.
                from_fifo      = (remain_q != '0);
                tx_axis_tvalid = from_fifo ? !fifo_empty : 1'b1;
                tx_axis_tdata  = (from_fifo && !fifo_empty) ? fifo_head : 8'h00;
                sent_after     = {1'b0, cnt_q} + 17'd1;
                tx_axis_tlast  = (remain_q <= 16'd1) &&
                                 (sent_after >= 17'(MIN_PAYLOAD));
                if (tx_axis_tvalid && tx_axis_tready) begin
                    fifo_pop = from_fifo;
                    cnt_d    = cnt_q + 16'd1;
                    if (from_fifo) begin
                        remain_d = remain_q - 16'd1;
                    end
                    if (tx_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
`else
                tx_axis_tvalid = !fifo_empty;
                tx_axis_tdata  = fifo_empty ? 8'h00 : fifo_head;
                tx_axis_tlast  = (remain_q == 16'd1);
                if (tx_axis_tvalid && tx_axis_tready) begin
                    fifo_pop = 1'b1;
                    remain_d = remain_q - 16'd1;
                    cnt_d    = cnt_q + 16'd1;
                    if (tx_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_transmitter.sv
// ---------------------------------------------------------------------------
// tb_transmitter
//   Directed bench for the transmitter frame builder. A negedge monitor
//   records every handshaked byte as {tlast, tdata}; scenario tasks build
//   the expected byte stream themselves and compare against it.
// ---------------------------------------------------------------------------
module tb_transmitter;
    import defines::*;

    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    address          header_addr;
    logic [1:0][7:0] number_of_bytes;
    logic            rx_header_valid;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_axis_tready;
    logic [7:0]      tx_axis_tdata;
    logic            tx_axis_tvalid;
    logic            tx_axis_tlast;
    logic            btx_full;

    int checks   = 0;
    int failures = 0;

    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int         gap_cnt   = 0;
    int         tlast_cnt = 0;
    bit         in_frame  = 1'b0;

    transmitter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .header_addr     (header_addr),
        .number_of_bytes (number_of_bytes),
        .rx_header_valid (rx_header_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_axis_tready  (tx_axis_tready),
        .tx_axis_tdata   (tx_axis_tdata),
        .tx_axis_tvalid  (tx_axis_tvalid),
        .tx_axis_tlast   (tx_axis_tlast),
        .btx_full        (btx_full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_axis_tvalid && tx_axis_tready) begin
                got.push_back({tx_axis_tlast, tx_axis_tdata});
                if (tx_axis_tlast) tlast_cnt++;
                in_frame = !tx_axis_tlast;
            end else if (in_frame && !tx_axis_tvalid) begin
                gap_cnt++;
            end
        end else begin
            in_frame = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // Appends one expected frame; payload byte i is base + i*step.
    function automatic void build_frame(input address a, input logic [15:0] len,
                                        input logic [7:0] base, input logic [7:0] step);
        int n;
        logic [7:0] b;
        for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, a.dst[i]});
        for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, a.src[i]});
        exp_q.push_back({1'b0, len[15:8]});
        exp_q.push_back({1'b0, len[7:0]});
        n = int'(len);
`ifdef TRANSMITTER_PAD_EN
        if (n < MIN_PAYLOAD) n = MIN_PAYLOAD;
`endif
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            exp_q.push_back({1'b0, (i < int'(len)) ? b : 8'h00});
        end
        exp_q[exp_q.size()-1][8] = 1'b1;
    endfunction

    task automatic apply_reset();
        rst_n           = 1'b0;
        rx_header_valid = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        tx_axis_tready  = 1'b1;
        header_addr     = '0;
        number_of_bytes = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base,
                              input logic [7:0] step, input bit alt);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'b1;
            tx_data  = base + 8'(i) * step;
            @(posedge clk); #1;
            if (alt) begin
                tx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        tx_valid = 1'b0;
    endtask

    // Drives a one-cycle header strobe, then checks the first dst byte is
    // presented in the cycle after capture.
    task automatic send_header(input address a, input logic [15:0] len);
        @(posedge clk); #1;
        header_addr     = a;
        number_of_bytes = len;
        rx_header_valid = 1'b1;
        @(posedge clk); #1;
        rx_header_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_axis_tvalid, tx_axis_tdata} !== {1'b1, a.dst[5]}) begin
            failures++;
            $display("FAIL hdr_latency: tvalid/tdata=%b/%h required 1/%h",
                     tx_axis_tvalid, tx_axis_tdata, a.dst[5]);
        end
    endtask

    task automatic wait_frame(input string name);
        int cyc = 0;
        int first = -1;
        while (got.size() < exp_q.size() && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                first = i;
                break;
            end
        end
        if (first < 0 && got.size() != exp_q.size()) first = exp_q.size();
        checks++;
        if (first >= 0) begin
            failures++;
            $display("FAIL %s: %0d bytes got, %0d required; first diff idx %0d got %h required %h",
                     name, got.size(), exp_q.size(), first,
                     (first < got.size()) ? got[first] : 9'h1ff,
                     (first < exp_q.size()) ? exp_q[first] : 9'h1ff);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        rx_header_valid = 1'b0;
        tx_valid        = 1'b1;
        tx_data         = 8'h55;
        tx_axis_tready  = 1'b1;
        header_addr     = '0;
        number_of_bytes = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tx_axis_tdata !== 8'h00) begin
            failures++; $display("FAIL reset_tdata: got %h required 00", tx_axis_tdata);
        end
        checks++;
        if (tx_axis_tvalid !== 1'b0) begin
            failures++; $display("FAIL reset_tvalid: got %b required 0", tx_axis_tvalid);
        end
        checks++;
        if (tx_axis_tlast !== 1'b0) begin
            failures++; $display("FAIL reset_tlast: got %b required 0", tx_axis_tlast);
        end
        checks++;
        if (btx_full !== 1'b0) begin
            failures++; $display("FAIL reset_full: got %b required 0", btx_full);
        end
        tx_valid = 1'b0;
        apply_reset();
    endtask

    task automatic test_basic_frame();
        address a;
        a.dst = {6{8'h3F}};
        a.src = {6{8'h3F}};
        gap_cnt = 0;
        build_frame(a, 16'h0020, 8'hCC, 8'h00);
        fork
            push_bytes(32, 8'hCC, 8'h00, 1'b1);
            send_header(a, 16'h0020);
        join
        wait_frame("basic_frame");
        checks++;
        if (!(gap_cnt > 0)) begin
            failures++;
            $display("FAIL basic_gaps: got %0d empty-FIFO gaps, required at least 1", gap_cnt);
        end
    endtask

    task automatic test_back_to_back();
        address a;
        a.dst = {6{8'h3F}};
        a.src = {6{8'h3F}};
        tlast_cnt = 0;
        for (int k = 0; k < 5; k++) build_frame(a, 16'h0020, 8'hCC, 8'h00);
        fork
            push_bytes(160, 8'hCC, 8'h00, 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin
                        int cyc = 0;
                        while (!(tx_axis_tvalid && tx_axis_tready && tx_axis_tlast) && cyc < 3000) begin
                            @(negedge clk);
                            cyc++;
                        end
                        if (cyc >= 3000) begin
                            checks++; failures++;
                            $display("FAIL b2b_tlast_wait: frame %0d no tlast, required one", k);
                            break;
                        end
                    end
                    send_header(a, 16'h0020);
                end
            end
        join
        wait_frame("back_to_back");
        checks++;
        if (tlast_cnt !== 5) begin
            failures++; $display("FAIL b2b_tlast_count: got %0d required 5", tlast_cnt);
        end
    endtask

    task automatic stall_hold(input string name);
        logic [9:0] snap;
        bit         held = 1'b1;
        tx_axis_tready = 1'b0;
        @(negedge clk);
        snap = {tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata};
        repeat (3) begin
            @(negedge clk);
            if ({tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata} !== snap) held = 1'b0;
        end
        @(posedge clk); #1;
        tx_axis_tready = 1'b1;
        checks++;
        if (held !== 1'b1) begin
            failures++; $display("FAIL %s_hold: outputs changed under stall, required stable from %h", name, snap);
        end
        checks++;
        if (snap[9] !== 1'b1) begin
            failures++; $display("FAIL %s_valid: tvalid %b during stall, required 1", name, snap[9]);
        end
    endtask

    task automatic test_backpressure();
        address a;
        a.dst = 48'h11_12_13_14_15_16;
        a.src = 48'h21_22_23_24_25_26;
        build_frame(a, 16'h0020, 8'h40, 8'h01);
        push_bytes(32, 8'h40, 8'h01, 1'b0);
        send_header(a, 16'h0020);
        @(posedge clk); #1;
        @(posedge clk); #1;
        stall_hold("stall_dst");
        repeat (16) @(posedge clk);
        #1;
        stall_hold("stall_payload");
        wait_frame("backpressure_frame");
    endtask

    task automatic test_overflow();
        address a;
        a.dst = 48'hA1_A2_A3_A4_A5_A6;
        a.src = 48'hB1_B2_B3_B4_B5_B6;
        push_bytes(DEPTH - 1, 8'h00, 8'h01, 1'b0);
        @(negedge clk);
        checks++;
        if (btx_full !== 1'b0) begin
            failures++; $display("FAIL full_at_63: got %b required 0", btx_full);
        end
        push_bytes(1, 8'h3F, 8'h01, 1'b0);
        @(negedge clk);
        checks++;
        if (btx_full !== 1'b1) begin
            failures++; $display("FAIL full_at_64: got %b required 1", btx_full);
        end
        push_bytes(3, 8'h40, 8'h01, 1'b0);
        @(negedge clk);
        checks++;
        if (btx_full !== 1'b1) begin
            failures++; $display("FAIL full_after_drop: got %b required 1", btx_full);
        end
        build_frame(a, 16'd64, 8'h00, 8'h01);
        send_header(a, 16'd64);
        wait_frame("overflow_frame");
        checks++;
        if ({btx_full, tx_axis_tvalid} !== 2'b00) begin
            failures++; $display("FAIL overflow_drained: full/tvalid=%b/%b required 0/0", btx_full, tx_axis_tvalid);
        end
    endtask

    task automatic test_len0();
        address a;
        a.dst = 48'h01_02_03_04_05_06;
        a.src = 48'h0A_0B_0C_0D_0E_0F;
        build_frame(a, 16'h0000, 8'h00, 8'h00);
        send_header(a, 16'h0000);
        wait_frame("len0_frame");
    endtask

    task automatic test_reset_mid_frame();
        address a;
        a.dst = {6{8'h3F}};
        a.src = {6{8'h3F}};
        push_bytes(32, 8'h80, 8'h01, 1'b0);
        send_header(a, 16'h0020);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata, btx_full} !== 11'b0) begin
            failures++;
            $display("FAIL reset_mid: tvalid/tlast/tdata/full=%b/%b/%h/%b required all 0",
                     tx_axis_tvalid, tx_axis_tlast, tx_axis_tdata, btx_full);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        build_frame(a, 16'h0020, 8'hCC, 8'h00);
        fork
            push_bytes(32, 8'hCC, 8'h00, 1'b1);
            send_header(a, 16'h0020);
        join
        wait_frame("after_reset_frame");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_len0();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
